// File: rtl/mac_pkg.sv
// Shared types for the dot-product MAC slice: operand/accumulator types and
// the sequencer state encoding.
package mac_pkg;

    localparam int W = 10;

    typedef logic signed [W-1:0]   operand_t;
    typedef logic signed [2*W-1:0] acc_t;

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        RUN,
        DRAIN,
        OUT
    } ctrl_state_t;

endpackage

// File: rtl/mac_vec_buf.sv
// N-entry operand buffer: one write port, one registered read port feeding the
// MAC operand inputs directly.
module mac_vec_buf #(
    parameter int N  = 8,
    parameter int W  = 10,
    parameter int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W-1:0] wa,
    input  logic signed [W-1:0] wb,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic signed [W-1:0] ra,
    output logic signed [W-1:0] rb
);

    logic signed [W-1:0] mem_a [N];
    logic signed [W-1:0] mem_b [N];

    // Storage is never reset; its contents only matter once a full vector is loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_a[waddr] <= wa;
            mem_b[waddr] <= wb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra <= '0;
            rb <= '0;
        end else if (re) begin
            ra <= mem_a[raddr];
            rb <= mem_b[raddr];
        end
    end

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: buffers N operand pairs, clears the MAC, issues the
// pairs back-to-back, counts MAC results and presents the final accumulation.
module mac_dot_ctrl
    import mac_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 10,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [W-1:0]   s_a,
    input  logic signed [W-1:0]   s_b,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic signed [2*W-1:0] m_f,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W-1:0]   mac_a,
    output logic signed [W-1:0]   mac_b,
    output logic                  mac_valid_in,
    output logic                  mac_clear,
    input  logic signed [2*W-1:0] mac_f,
    input  logic                  mac_valid_out
);

    localparam int AW = $clog2(N);

    ctrl_state_t   state, next_state;
    logic [CW-1:0] wr_cnt, rd_cnt, vo_cnt;
    logic          last_wr, last_rd, last_vo;
    logic          buf_we, buf_re, vo_en;

    assign last_wr = (wr_cnt == CW'(N - 1));
    assign last_rd = (rd_cnt == CW'(N - 1));
    assign last_vo = (vo_cnt == CW'(N - 1));

    mac_vec_buf #(
        .N  (N),
        .W  (W),
        .AW (AW)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (wr_cnt[AW-1:0]),
        .wa    (s_a),
        .wb    (s_b),
        .re    (buf_re),
        .raddr (rd_cnt[AW-1:0]),
        .ra    (mac_a),
        .rb    (mac_b)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (s_valid && last_wr)       next_state = CLEAR;
            CLEAR:                                 next_state = RUN;
            RUN:     if (last_rd)                  next_state = DRAIN;
            DRAIN:   if (mac_valid_out && last_vo) next_state = OUT;
            OUT:     if (m_ready)                  next_state = LOAD;
            default:                               next_state = LOAD;
        endcase
    end

    // Result pulses are only meaningful once issue has started; stray ones
    // left over from an aborted job are dropped outside RUN/DRAIN.
    always_comb begin
        s_ready = (state == LOAD);
        buf_we  = s_valid && (state == LOAD);
        buf_re  = (state == RUN);
        vo_en   = mac_valid_out && ((state == RUN) || (state == DRAIN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            vo_cnt       <= '0;
            m_f          <= '0;
            m_valid      <= 1'b0;
            mac_valid_in <= 1'b0;
            mac_clear    <= 1'b0;
        end else begin
            // Read data lands in mac_a/mac_b on the same edge as this valid.
            mac_valid_in <= (state == RUN);
            mac_clear    <= (state == CLEAR);
            if (buf_we) wr_cnt <= last_wr ? '0 : wr_cnt + CW'(1);
            if (buf_re) rd_cnt <= rd_cnt + CW'(1);
            if (vo_en)  vo_cnt <= vo_cnt + CW'(1);
            if ((state == DRAIN) && mac_valid_out && last_vo) begin
                m_f     <= mac_f;
                m_valid <= 1'b1;
            end
            if ((state == OUT) && m_ready) begin
                m_valid <= 1'b0;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                vo_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Bench for mac_dot_ctrl with a 2-cycle MAC stand-in; results are compared
// against a plain arithmetic dot product wrapped to 2W bits.
module tb_mac_dot_ctrl;

    localparam int N = 8;
    localparam int W = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic signed [W-1:0]   s_a, s_b;
    logic                  s_valid;
    logic                  s_ready;
    logic signed [2*W-1:0] m_f;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [W-1:0]   mac_a, mac_b;
    logic                  mac_valid_in;
    logic                  mac_clear;
    logic signed [2*W-1:0] mac_f;
    logic                  mac_valid_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mac_dot_ctrl #(.N(N), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_a           (s_a),
        .s_b           (s_b),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_f           (m_f),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_clear     (mac_clear),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out)
    );

    // MAC stand-in: product stage then accumulate stage, reset by reset|clear.
    logic signed [2*W-1:0] prod;
    logic                  prod_v;
    always @(posedge clk) begin
        if (reset || mac_clear) begin
            prod          <= '0;
            prod_v        <= 1'b0;
            mac_valid_out <= 1'b0;
            mac_f         <= '0;
        end else begin
            prod          <= mac_a * mac_b;
            prod_v        <= mac_valid_in;
            mac_valid_out <= prod_v;
            if (prod_v) mac_f <= mac_f + prod;
        end
    end

    int   clr_total = 0;
    int   vin_total = 0;
    int   vin_rise  = 0;
    logic vin_prev  = 1'b0;
    always @(negedge clk) begin
        if (mac_clear) clr_total++;
        if (mac_valid_in) vin_total++;
        if (mac_valid_in && !vin_prev) vin_rise++;
        vin_prev = mac_valid_in;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_dot(input int av[N], input int bv[N]);
        longint s;
        longint mask;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(av[i]) * longint'(bv[i]);
        mask = (longint'(1) << (2 * W)) - 1;
        s = s & mask;
        if (s >= (longint'(1) << (2 * W - 1))) s -= longint'(1) << (2 * W);
        return s;
    endfunction

    // gaps: 0 = streamed, 1 = valid every other cycle, 2 = random gaps
    task automatic load_vec(input string tag, input int av[N], input int bv[N], input int gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < N && guard < 100) begin
            if ((gaps == 1 && guard % 2 == 1) || (gaps == 2 && $urandom_range(0, 1) == 0)) begin
                s_valid = 1'b0;
                s_a     = W'($urandom);
                s_b     = W'($urandom);
            end else begin
                s_valid = 1'b1;
                s_a     = W'(av[i]);
                s_b     = W'(bv[i]);
            end
            if (s_valid && s_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        check({tag, "_loaded"}, longint'(i), longint'(N));
    endtask

    task automatic run_job(input string tag, input int av[N], input int bv[N],
                           input int gaps, input int stall);
        int     c0, v0, r0, guard, busy_ready;
        longint exp;
        exp     = ref_dot(av, bv);
        c0      = clr_total;
        v0      = vin_total;
        r0      = vin_rise;
        m_ready = (stall == 0);
        load_vec(tag, av, bv, gaps);
        guard      = 0;
        busy_ready = 0;
        while (!m_valid && guard < 100) begin
            s_valid = 1'b1;
            s_a     = W'($urandom);
            s_b     = W'($urandom);
            if (s_ready) busy_ready++;
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0;
        check({tag, "_busy_sready"}, longint'(busy_ready), 0);
        check({tag, "_mvalid"}, longint'(m_valid), 1);
        check({tag, "_mf"}, longint'(m_f), exp);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check({tag, "_stall_mvalid"}, longint'(m_valid), 1);
            check({tag, "_stall_mf"}, longint'(m_f), exp);
            check({tag, "_stall_sready"}, longint'(s_ready), 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_mvalid_drop"}, longint'(m_valid), 0);
        check({tag, "_sready_back"}, longint'(s_ready), 1);
        check({tag, "_clear_pulses"}, longint'(clr_total - c0), 1);
        check({tag, "_issue_cycles"}, longint'(vin_total - v0), longint'(N));
        check({tag, "_issue_bursts"}, longint'(vin_rise - r0), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int av[N];
    int bv[N];

    initial begin
        int issued;
        int stray;
        reset   = 1'b1;
        s_valid = 1'b1;
        s_a     = 10'sd77;
        s_b     = -10'sd5;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mvalid", longint'(m_valid), 0);
        check("rst_mf", longint'(m_f), 0);
        check("rst_mac_a", longint'(mac_a), 0);
        check("rst_mac_b", longint'(mac_b), 0);
        check("rst_mac_vin", longint'(mac_valid_in), 0);
        check("rst_mac_clear", longint'(mac_clear), 0);
        reset   = 1'b0;
        s_valid = 1'b0;
        check("rst_sready", longint'(s_ready), 1);

        for (int i = 0; i < N; i++) begin av[i] = i + 1; bv[i] = i + 1; end
        run_job("basic", av, bv, 0, 0);
        run_job("gaps", av, bv, 1, 5);

        for (int i = 0; i < N; i++) begin av[i] = -3; bv[i] = 7; end
        run_job("b2b", av, bv, 0, 0);

        for (int i = 0; i < N; i++) begin av[i] = -512; bv[i] = -512; end
        run_job("wrap", av, bv, 0, 0);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < N; i++) begin
                av[i] = int'($urandom_range(0, 1023)) - 512;
                bv[i] = int'($urandom_range(0, 1023)) - 512;
            end
            run_job($sformatf("rand%0d", j), av, bv, 2, int'($urandom_range(0, 4)));
        end

        for (int i = 0; i < N; i++) begin
            av[i] = int'($urandom_range(0, 1023)) - 512;
            bv[i] = int'($urandom_range(0, 1023)) - 512;
        end
        m_ready = 1'b1;
        load_vec("abort", av, bv, 0);
        issued = 0;
        for (int k = 0; k < 20 && issued < 3; k++) begin
            if (mac_valid_in) issued++;
            if (issued < 3) begin @(posedge clk); #1; end
        end
        check("abort_third_issue", longint'(issued), 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_mvalid", longint'(m_valid), 0);
        check("abort_sready", longint'(s_ready), 1);
        check("abort_mac_vin", longint'(mac_valid_in), 0);
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_valid) stray++;
            @(posedge clk); #1;
        end
        check("abort_no_result", longint'(stray), 0);

        for (int i = 0; i < N; i++) begin av[i] = 2; bv[i] = 3; end
        run_job("after_abort", av, bv, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
